imem_fetch: RTL and testbench
=============================

# imem_fetch

Instruction fetch stage that sits directly downstream of IMEM. Holds the program counter, drives IMEM's read address, captures the returned 16-bit word into an output register, and presents it to decode with a valid/ready handshake. Supports PC redirect (branch/jump), a halt word that stops fetching, and PC wrap-around at the programmed length. IMEM's shift-loading is owned by the system controller. Fetch must be held in IDLE (`run=0`) while IMEM is being loaded.

## Interface
Parameters:
- `ADDR_W`, 6: IMEM address width (64 words).
- `DATA_W`, 16: instruction width.
- `PROG_LEN`, 64: PC wraps to 0 after `PROG_LEN-1`; legal range 1..2^ADDR_W.
- `HALT_WORD`, 16'hFFFF: instruction encoding that halts fetch.

Ports:
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `run`  in  1: fetch enable from system controller.
- `imem_addr`  out  ADDR_W: IMEM read address (connects to IMEM `addr`).
- `imem_data`  in  DATA_W: IMEM read data (connects to IMEM `data_out`), combinational read of `imem_addr`.
- `instr`  out  DATA_W: registered instruction to decode.
- `instr_pc`  out  ADDR_W: address `instr` was fetched from.
- `instr_valid`  out  1: `instr`/`instr_pc` valid.
- `instr_ready`  in  1: decode accepts `instr` this cycle.
- `redirect`  in  1: load new PC, flush held instruction.
- `redirect_addr`  in  ADDR_W: new PC.
- `halted`  out  1: halt word fetched, fetching stopped.
- `fetch_count`  out  16: instructions delivered (only with `IMEM_FETCH_PERF_EN`).

## Operation
- States: IDLE, FETCH, HALT (2-bit encoded, registered).
- `imem_addr` = `pc` register, combinational.
- Slot free = `!instr_valid || instr_ready`. Accept = `instr_valid && instr_ready`.
- IDLE: no capture. `run=1` moves to FETCH. `redirect` loads `pc` and stays IDLE. A held `instr_valid` stays until accepted.
- FETCH, slot free, no redirect:
  - `instr <= imem_data`, `instr_pc <= pc`, `instr_valid <= 1`.
  - `pc <= (pc == PROG_LEN-1) ? 0 : pc+1`.
- FETCH, slot not free: hold `instr`, `instr_pc`, and `pc`.
- Captured word equal to `HALT_WORD`:
  - It is delivered to decode like any other word.
  - State goes to HALT and `halted` is set on the same edge.
  - `pc` still increments.
- HALT: no capture. `instr_valid` clears on accept.
- `run=0` in FETCH: go to IDLE next edge with no capture that cycle.
- `redirect=1` (any state) has top priority:
  - `pc <= redirect_addr`, `instr_valid <= 0`; the held word is dropped even if `instr_ready=1`.
  - `halted <= 0`.
  - From HALT or FETCH, next state is FETCH if `run=1`, else IDLE.
- `redirect_addr >= PROG_LEN`: loaded as-is, wraps to 0 after the increment from `PROG_LEN-1` rule fails. Implementation compares `pc >= PROG_LEN-1` for wrap.

## Timing
- Reset values: `pc=0`, state IDLE, `instr=0`, `instr_pc=0`, `instr_valid=0`, `halted=0`, `imem_addr=0`, `fetch_count=0`.
- `rst` low mid-operation clears everything on the next edge regardless of handshake.
- Latency: from `run` high, first `instr_valid` is 2 edges later (IDLE→FETCH, then capture).
- Redirect-to-valid is 1 edge when in FETCH with `run=1`: the edge after redirect captures from `redirect_addr`.
- Throughput: 1 instruction/cycle with `instr_ready` held high.
- `instr`/`instr_pc` stable while `instr_valid && !instr_ready`.

## Configuration
- `IMEM_FETCH_PERF_EN` defined:
  - `fetch_count` increments on each accept, saturating at 16'hFFFF.
  - Clears on reset only; not on redirect.
- Not defined: `fetch_count` is tied to 0 and no counter flop is built.

## Test plan
- Reset: hold `rst=0` with `run=1`, `redirect=1` → all outputs 0, state IDLE; release → IDLE until `run`.
- Stream: IMEM[0..2]=AAAA,BBBB,CCCC, `run=1`, `instr_ready=1` → valid words AAAA/0, BBBB/1, CCCC/2 on consecutive cycles starting 2 edges after `run`.
- Backpressure: drop `instr_ready` for 3 cycles while `instr=BBBB` → BBBB/1 held stable, `imem_addr` stays 2; raise ready → CCCC/2 next cycle, nothing lost or duplicated.
- Redirect: `redirect=1`, `redirect_addr=5` while BBBB valid and ready=1 → BBBB not counted; next valid is IMEM[5]/5.
- Halt + wrap:
  - IMEM[3]=FFFF → FFFF/3 delivered, `halted=1`, no further valid.
  - Redirect to 63 → IMEM[63]/63 then IMEM[0]/0.
- Perf (`IMEM_FETCH_PERF_EN`): 3 accepts plus 1 flushed word → `fetch_count=3`; without macro → 0.

Source files
------------

// File: rtl/imem_fetch.sv
// imem_fetch: instruction fetch stage sitting directly downstream of IMEM.
// It holds the program counter, drives the IMEM read address, and registers
// the returned word. The word goes to decode over a valid/ready handshake.
// Fetch supports PC redirect, a halt word that stops fetching, and PC
// wrap-around at PROG_LEN.
//
// Optional feature macro: IMEM_FETCH_PERF_EN
//   defined   -> fetch_count counts accepted instructions and saturates.
//   undefined -> fetch_count is tied to 0 and no counter is built.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-low reset
//   run           in   fetch enable from the system controller
//   imem_addr     out  IMEM read address (equal to the PC)
//   imem_data     in   IMEM combinational read data for imem_addr
//   instr         out  registered instruction to decode
//   instr_pc      out  address instr was fetched from
//   instr_valid   out  instr/instr_pc valid
//   instr_ready   in   decode accepts instr this cycle
//   redirect      in   load redirect_addr into PC, flush held instruction
//   redirect_addr in   new PC
//   halted        out  halt word fetched, fetching stopped
//   fetch_count   out  delivered-instruction count (perf build only)
module imem_fetch #(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 16,
    parameter int                PROG_LEN  = 64,
    parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // One bit wider than the PC so that PROG_LEN = 2^ADDR_W is representable.
    localparam logic [ADDR_W:0] LAST_PC = (ADDR_W+1)'(PROG_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic              slot_free;
    logic              accept;
    logic              capture;
    logic              is_halt;

    assign imem_addr = pc;
    assign slot_free = !instr_valid || instr_ready;
    assign accept    = instr_valid && instr_ready;
    assign is_halt   = (imem_data == HALT_WORD);

    // The ">=" comparison also wraps a redirect target at or beyond
    // PROG_LEN back to 0 after its first fetch.
    assign pc_inc = ({1'b0, pc} >= LAST_PC) ? '0 : pc + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        if (redirect) begin
            // Redirect has top priority. IDLE only reloads the PC.
            if (state != IDLE) begin
                state_next = run ? FETCH : IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (!run) begin
                        state_next = IDLE;
                    end else if (slot_free) begin
                        capture = 1'b1;
                        if (is_halt) begin
                            state_next = HALT;
                        end
                    end
                end
                HALT: begin
                    state_next = HALT;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect) begin
            pc          <= redirect_addr;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else if (capture) begin
            instr       <= imem_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            pc          <= pc_inc;
            if (is_halt) begin
                halted <= 1'b1;
            end
        end else if (accept) begin
            instr_valid <= 1'b0;
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    logic [15:0] count_q;

    // A word flushed by redirect is not counted, even when instr_ready is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (accept && !redirect && (count_q != '1)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch. It uses a spec-level cycle model and
// directed stimulus, and adds literal expectations at key points.
module tb_imem_fetch;

    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 16;
    localparam int PROG_LEN = 64;
    localparam logic [DATA_W-1:0] HALT_W = 16'hFFFF;

    logic              clk;
    logic              rst;
    logic              run;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              halted;
    logic [15:0]       fetch_count;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int vectors = 0;
    int errors  = 0;

    typedef enum int {M_IDLE, M_FETCH, M_HALT} mode_t;
    mode_t             m_mode;
    int                m_pc;
    logic [DATA_W-1:0] m_instr;
    int                m_ipc;
    bit                m_valid;
    bit                m_halted;
    int                m_count;

    imem_fetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .PROG_LEN (PROG_LEN),
        .HALT_WORD(HALT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one rising edge using the spec rules.
    task automatic model_step();
        bit acc;
        if (!rst) begin
            m_mode = M_IDLE; m_pc = 0; m_instr = '0; m_ipc = 0;
            m_valid = 0; m_halted = 0; m_count = 0;
        end else if (redirect) begin
            m_pc = int'(redirect_addr);
            m_valid = 0;
            m_halted = 0;
            if (m_mode != M_IDLE) m_mode = run ? M_FETCH : M_IDLE;
        end else begin
            acc = m_valid && instr_ready;
            if (acc && m_count < 65535) m_count++;
            if (m_mode == M_FETCH && run && (!m_valid || instr_ready)) begin
                m_instr = mem[m_pc];
                m_ipc   = m_pc;
                m_valid = 1;
                m_pc    = (m_pc >= PROG_LEN - 1) ? 0 : m_pc + 1;
                if (m_instr == HALT_W) begin
                    m_mode = M_HALT;
                    m_halted = 1;
                end
            end else begin
                if (acc) m_valid = 0;
                if (m_mode == M_IDLE && run) m_mode = M_FETCH;
                else if (m_mode == M_FETCH && !run) m_mode = M_IDLE;
            end
        end
    endtask

    // One clock: update the model on the edge, then compare #1 later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("imem_addr", 32'(imem_addr), 32'(m_pc));
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_halted));
        if (m_valid) begin
            chk("instr", 32'(instr), 32'(m_instr));
            chk("instr_pc", 32'(instr_pc), 32'(m_ipc));
        end
`ifdef IMEM_FETCH_PERF_EN
        chk("fetch_count", 32'(fetch_count), 32'(m_count));
`else
        chk("fetch_count", 32'(fetch_count), 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h1000 + 16'(i);
        mem[0]  = 16'hAAAA;
        mem[1]  = 16'hBBBB;
        mem[2]  = 16'hCCCC;
        mem[3]  = 16'hFFFF;
        mem[5]  = 16'h5555;
        mem[63] = 16'h6363;

        // Reset dominates run and redirect.
        rst = 1'b0; run = 1'b1; redirect = 1'b1; redirect_addr = 6'd9; instr_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);

        rst = 1'b1; run = 1'b0; redirect = 1'b0;
        tick(); tick();
        chk("idle_valid", 32'(instr_valid), 32'd0);

        // Stream with two-edge start latency.
        run = 1'b1; instr_ready = 1'b1;
        tick();
        chk("lat_valid", 32'(instr_valid), 32'd0);
        tick();
        chk("s0_instr", 32'(instr), 32'h0000AAAA);
        chk("s0_pc", 32'(instr_pc), 32'd0);
        tick();
        chk("s1_instr", 32'(instr), 32'h0000BBBB);

        // Backpressure holds BBBB/1 and the PC.
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_instr", 32'(instr), 32'h0000BBBB);
            chk("bp_pc", 32'(instr_pc), 32'd1);
            chk("bp_addr", 32'(imem_addr), 32'd2);
        end
        instr_ready = 1'b1;
        tick();
        chk("s2_instr", 32'(instr), 32'h0000CCCC);
        chk("s2_pc", 32'(instr_pc), 32'd2);

        // The halt word is delivered and fetching stops.
        tick();
        chk("halt_instr", 32'(instr), 32'h0000FFFF);
        chk("halt_flag", 32'(halted), 32'd1);
        tick();
        chk("halt_novalid", 32'(instr_valid), 32'd0);
        chk("halt_addr", 32'(imem_addr), 32'd4);
        tick();

        // Redirect out of HALT, then flush BBBB with a redirect to 5.
        redirect = 1'b1; redirect_addr = 6'd0;
        tick();
        chk("rd_halted", 32'(halted), 32'd0);
        redirect = 1'b0;
        tick(); tick();
        redirect = 1'b1; redirect_addr = 6'd5;
        tick();
        chk("flush_valid", 32'(instr_valid), 32'd0);
        redirect = 1'b0;
        tick();
        chk("rd5_instr", 32'(instr), 32'h00005555);
        chk("rd5_pc", 32'(instr_pc), 32'd5);

        // Wrap from 63 to 0.
        redirect = 1'b1; redirect_addr = 6'd63;
        tick();
        redirect = 1'b0;
        tick();
        chk("w63_instr", 32'(instr), 32'h00006363);
        tick();
        chk("w0_instr", 32'(instr), 32'h0000AAAA);
        chk("w0_pc", 32'(instr_pc), 32'd0);

        // Mid-run reset, then 3 accepts and 1 flushed word.
        rst = 1'b0;
        tick();
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_addr", 32'(imem_addr), 32'd0);
        rst = 1'b1;
        repeat (5) tick();
        redirect = 1'b1; redirect_addr = 6'd4;
        tick();
`ifdef IMEM_FETCH_PERF_EN
        chk("perf_count", 32'(fetch_count), 32'd3);
`else
        chk("perf_count", 32'(fetch_count), 32'd0);
`endif

        // run=0 in FETCH goes idle without a capture.
        redirect = 1'b0; run = 1'b0;
        tick();
        chk("stop_valid", 32'(instr_valid), 32'd0);
        chk("stop_addr", 32'(imem_addr), 32'd4);
        run = 1'b1;
        tick(); tick();
        chk("resume_instr", 32'(instr), 32'h00001004);
        chk("resume_pc", 32'(instr_pc), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
